// File: rtl/mandelbrot_pkg.sv
// Shared constants and FSM encoding for the Mandelbrot iteration path.
// Complex components are signed Q4.28; the step unit squares them and realigns.
package mandelbrot_pkg;

    localparam int WORD_LEN      = 32;
    localparam int FRAC_BITS     = 28;
    localparam int ITER_W        = 16;
    // Right shift that brings a Q8.56 product back to Q4.28.
    localparam int PRE_MUL_SHIFT = FRAC_BITS;
    // Escape radius squared (4.0) in Q4.28.
    localparam logic [WORD_LEN-1:0] MANDEL_INFINITY = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ITERATE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration sequencer: feeds z/c to the external z^2+c step unit each
// cycle, counts iterations until escape or the limit, and hands back the count.
module mandelbrot_iter_ctrl #(
    parameter int WORD_LEN  = mandelbrot_pkg::WORD_LEN,
    parameter int FRAC_BITS = mandelbrot_pkg::FRAC_BITS,
    parameter int ITER_W    = mandelbrot_pkg::ITER_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [WORD_LEN-1:0] c_real,
    input  logic [WORD_LEN-1:0] c_imag,
    input  logic [ITER_W-1:0]   max_iter,
    output logic [WORD_LEN-1:0] z_real_o,
    output logic [WORD_LEN-1:0] z_imag_o,
    output logic [WORD_LEN-1:0] c_real_o,
    output logic [WORD_LEN-1:0] c_imag_o,
    input  logic [WORD_LEN-1:0] next_z_real,
    input  logic [WORD_LEN-1:0] next_z_imag,
    input  logic                finished,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [ITER_W-1:0]   iter_count,
    output logic                escaped,
    output logic [1:0]          dbg_state
);
    import mandelbrot_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and ready depends only on state.

    if (FRAC_BITS >= WORD_LEN) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than WORD_LEN");
    end

    state_t              state, state_nxt;
    logic [WORD_LEN-1:0] z_real_q, z_imag_q, c_real_q, c_imag_q;
    logic [ITER_W-1:0]   cnt, limit, cnt_inc, iter_count_q;
    logic                escaped_q;

    assign cnt_inc      = cnt + ITER_W'(1);
    assign z_real_o     = z_real_q;
    assign z_imag_o     = z_imag_q;
    assign c_real_o     = c_real_q;
    assign c_imag_o     = c_imag_q;
    assign iter_count   = iter_count_q;
    assign escaped      = escaped_q;
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid)
                    state_nxt = (max_iter == '0) ? DONE : ITERATE;
            end
            ITERATE: begin
                if (finished || cnt_inc == limit)
                    state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_real_q     <= '0;
            z_imag_q     <= '0;
            c_real_q     <= '0;
            c_imag_q     <= '0;
            cnt          <= '0;
            limit        <= '0;
            iter_count_q <= '0;
            escaped_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        c_real_q <= c_real;
                        c_imag_q <= c_imag;
                        limit    <= max_iter;
                        z_real_q <= '0;
                        z_imag_q <= '0;
                        cnt      <= '0;
                        if (max_iter == '0) begin
                            iter_count_q <= '0;
                            escaped_q    <= 1'b0;
                        end
                    end
                end
                ITERATE: begin
                    // Escape wins over the limit; z is left at the escaping value.
                    if (finished) begin
                        iter_count_q <= cnt;
                        escaped_q    <= 1'b1;
                    end else begin
                        z_real_q <= next_z_real;
                        z_imag_q <= next_z_imag;
                        cnt      <= cnt_inc;
                        if (cnt_inc == limit) begin
                            iter_count_q <= limit;
                            escaped_q    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Directed bench for mandelbrot_iter_ctrl with a behavioural Q4.28 step unit.
module tb_mandelbrot_iter_ctrl;
    import mandelbrot_pkg::*;

    localparam int WL        = 32;
    localparam int IW        = 16;
    localparam int LAT_LIMIT = 70000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid, start_ready;
    logic [WL-1:0] c_real, c_imag;
    logic [IW-1:0] max_iter;
    logic [WL-1:0] z_real_o, z_imag_o, c_real_o, c_imag_o;
    logic [WL-1:0] next_z_real, next_z_imag;
    logic          finished;
    logic          result_valid, result_ready;
    logic [IW-1:0] iter_count;
    logic          escaped;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .c_real(c_real), .c_imag(c_imag), .max_iter(max_iter),
        .z_real_o(z_real_o), .z_imag_o(z_imag_o),
        .c_real_o(c_real_o), .c_imag_o(c_imag_o),
        .next_z_real(next_z_real), .next_z_imag(next_z_imag),
        .finished(finished),
        .result_valid(result_valid), .result_ready(result_ready),
        .iter_count(iter_count), .escaped(escaped),
        .dbg_state(dbg_state)
    );

    // Step unit: z' = z^2 + c, finished = |z|^2 > 4, all in Q4.28.
    logic signed [63:0] rr, ii, ri, diff;
    logic [64:0]        mag;
    always_comb begin
        rr          = $signed(z_real_o) * $signed(z_real_o);
        ii          = $signed(z_imag_o) * $signed(z_imag_o);
        ri          = $signed(z_real_o) * $signed(z_imag_o);
        diff        = rr - ii;
        mag         = {1'b0, rr} + {1'b0, ii};
        finished    = mag > ({33'd0, MANDEL_INFINITY} << PRE_MUL_SHIFT);
        next_z_real = diff[PRE_MUL_SHIFT +: WL] + c_real_o;
        next_z_imag = ri[PRE_MUL_SHIFT-1 +: WL] + c_imag_o;
    end

    typedef struct {
        logic [WL-1:0] cr;
        logic [WL-1:0] ci;
        logic [IW-1:0] mi;
        logic [IW-1:0] cnt;
        logic          esc;
        int            lat;
    } vec_t;

    vec_t vecs[10];
    logic [IW:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_point(input logic [WL-1:0] cr, input logic [WL-1:0] ci,
                             input logic [IW-1:0] mi,
                             output logic [IW-1:0] cnt, output logic esc, output int lat);
        @(negedge clk);
        c_real = cr; c_imag = ci; max_iter = mi; start_valid = 1'b1;
        check("accept_ready", {63'd0, start_ready}, 64'd1);
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < LAT_LIMIT) begin
            @(posedge clk);
            #1 lat++;
        end
        cnt = iter_count;
        esc = escaped;
    endtask

    task automatic handoff();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        check("handoff_ready", {62'd0, start_ready, result_valid}, 64'd2);
    endtask

    logic [IW-1:0] got_cnt;
    logic          got_esc;
    int            got_lat;
    int            acc_cyc[4], hand_cyc[4];
    int            p[4] = '{0, 1, 5, 6};

    initial begin
        //          c_real        c_imag        max      cnt      esc   lat
        vecs[0] = '{32'h0000_0000, 32'h1800_0000, 16'd16,  16'd2,   1'b1, 4};
        vecs[1] = '{32'hE000_0000, 32'h0000_0000, 16'd5,   16'd5,   1'b0, 6};
        vecs[2] = '{32'h1234_5678, 32'h0ABC_DEF0, 16'd0,   16'd0,   1'b0, 1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 16'd7,   16'd7,   1'b0, 8};
        vecs[4] = '{32'h2000_0000, 32'h0000_0000, 16'd10,  16'd2,   1'b1, 4};
        vecs[5] = '{32'h3000_0000, 32'h0000_0000, 16'd4,   16'd1,   1'b1, 3};
        vecs[6] = '{32'h3000_0000, 32'h0000_0000, 16'd1,   16'd1,   1'b0, 2};
        vecs[7] = '{32'h3000_0000, 32'h0000_0000, 16'd2,   16'd1,   1'b1, 3};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 16'd1,   16'd1,   1'b0, 2};
        vecs[9] = '{32'h0000_0000, 32'h0000_0000, 16'hFFFF, 16'hFFFF, 1'b0, 65536};

        rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
        c_real = '0; c_imag = '0; max_iter = '0;
        #12;
        check("reset_start_ready", {63'd0, start_ready}, 64'd1);
        check("reset_result_valid", {63'd0, result_valid}, 64'd0);
        check("reset_z", {z_real_o, z_imag_o}, 64'd0);
        check("reset_c", {c_real_o, c_imag_o}, 64'd0);
        check("reset_result", {47'd0, escaped, iter_count}, 64'd0);
        check("reset_state", {62'd0, dbg_state}, {62'd0, IDLE});
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_point(vecs[i].cr, vecs[i].ci, vecs[i].mi, got_cnt, got_esc, got_lat);
            check($sformatf("vec%0d_count", i), {48'd0, got_cnt}, {48'd0, vecs[i].cnt});
            check($sformatf("vec%0d_escaped", i), {63'd0, got_esc}, {63'd0, vecs[i].esc});
            check($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(vecs[i].lat));
            handoff();
        end

        // Escape at k=2 for c=1.5i leaves z2 = -2.25 + 1.5i on the outputs.
        run_point(32'h0000_0000, 32'h1800_0000, 16'd16, got_cnt, got_esc, got_lat);
        check("done_z", {z_real_o, z_imag_o}, {32'hDC00_0000, 32'h1800_0000});
        check("done_c", {c_real_o, c_imag_o}, {32'h0000_0000, 32'h1800_0000});

        // Back-pressure in DONE with start_valid noise.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            c_real = $urandom; max_iter = 16'($urandom_range(1, 50));
            check("hold_flags", {62'd0, result_valid, start_ready}, 64'd2);
            check("hold_result", {47'd0, escaped, iter_count}, {47'd0, 1'b1, 16'd2});
            check("hold_z_c", {z_real_o, c_real_o}, {32'hDC00_0000, 32'h0000_0000});
        end
        @(negedge clk);
        start_valid = 1'b0;
        handoff();
        check("release_state", {62'd0, dbg_state}, {62'd0, IDLE});

        // Asynchronous reset in ITERATE at k=3.
        @(negedge clk);
        c_real = 32'h0400_0000; c_imag = '0; max_iter = 16'd8; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_state", {62'd0, dbg_state}, {62'd0, ITERATE});
        rst_n = 1'b0;
        #1;
        check("areset_z", {z_real_o, z_imag_o}, 64'd0);
        check("areset_c", {c_real_o, c_imag_o}, 64'd0);
        check("areset_result", {46'd0, result_valid, escaped, iter_count}, 64'd0);
        check("areset_start_ready", {63'd0, start_ready}, 64'd1);
        @(negedge clk) rst_n = 1'b1;
        run_point(vecs[0].cr, vecs[0].ci, vecs[0].mi, got_cnt, got_esc, got_lat);
        check("post_reset_result", {47'd0, got_esc, got_cnt}, {47'd0, 1'b1, 16'd2});
        check("post_reset_latency", 64'(got_lat), 64'd4);
        handoff();

        // Back-to-back points with result_ready tied high.
        begin
            int cyc = 0, a = 0, r = 0;
            logic [IW:0] req;
            result_ready = 1'b1;
            while (r < 4 && cyc < 400) begin
                @(negedge clk);
                if (a < 4) begin
                    c_real = vecs[p[a]].cr; c_imag = vecs[p[a]].ci;
                    max_iter = vecs[p[a]].mi; start_valid = 1'b1;
                end else begin
                    start_valid = 1'b0;
                end
                if (start_valid && start_ready) begin
                    acc_cyc[a] = cyc;
                    exp_q.push_back({vecs[p[a]].esc, vecs[p[a]].cnt});
                    a++;
                end
                if (result_valid && result_ready) begin
                    if (exp_q.size() == 0) begin
                        check("b2b_unexpected_result", 64'd1, 64'd0);
                    end else begin
                        req = exp_q.pop_front();
                        check("b2b_result", {47'd0, escaped, iter_count}, {47'd0, req});
                    end
                    hand_cyc[r] = cyc;
                    r++;
                end
                @(posedge clk);
                cyc++;
            end
            start_valid = 1'b0;
            result_ready = 1'b0;
            check("b2b_result_count", 64'(r), 64'd4);
            for (int i = 0; i < 3; i++)
                if (i + 1 < a && i < r)
                    check("b2b_accept_gap", 64'(acc_cyc[i+1]), 64'(hand_cyc[i] + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
